// File: rtl/nn_pkg.sv
// Shared types for the MNIST front end and neural_network: image geometry,
// pixel/image types and the loader FSM encoding.
package nn_pkg;

    localparam int unsigned N_PIX = 784;

    typedef logic signed [7:0] pixel_t;
    typedef pixel_t img_t [0:N_PIX-1];

    typedef enum logic [1:0] {
        StLoad,
        StStart,
        StRun,
        StResult
    } loader_state_t;

endpackage

// File: rtl/nn_img_buf.sv
// Image register bank: one write port with unsigned-to-0..127 conversion,
// full image exposed in parallel to the network.
module nn_img_buf #(
    parameter int unsigned N_PIX = 784
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en_i,
    input  logic [9:0]     wr_idx_i,
    input  logic [7:0]     wr_data_i,
    output nn_pkg::pixel_t img_o [0:N_PIX-1]
);

    nn_pkg::pixel_t img_q [0:N_PIX-1];
    nn_pkg::pixel_t img_d [0:N_PIX-1];

    always_comb begin
        img_d = img_q;
        // Dropping the LSB maps 0..255 onto the non-negative signed range.
        if (wr_en_i && ({22'b0, wr_idx_i} < N_PIX)) begin
            img_d[wr_idx_i] = {1'b0, wr_data_i[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            img_q <= '{default: '0};
        end else begin
            img_q <= img_d;
        end
    end

    assign img_o = img_q;

endmodule

// File: rtl/nn_img_loader.sv
// Loads a 784-pixel frame, runs neural_network to completion (or timeout)
// and offers the classified digit on a valid/ready port.
module nn_img_loader #(
    parameter int unsigned N_PIX   = 784,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     pix_data,
    input  logic           pix_sof,
    input  logic           pix_valid,
    output logic           pix_ready,
    output nn_pkg::pixel_t img [0:N_PIX-1],
    output logic           nn_reset,
    output logic           nn_enable,
    input  logic [7:0]     nn_digit,
    input  logic           nn_done,
    output logic [7:0]     digit_out,
    output logic           digit_err,
    output logic           digit_valid,
    input  logic           digit_ready
);

    localparam int unsigned TW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [9:0]    LAST_IDX = 10'(N_PIX - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    nn_pkg::loader_state_t state_q, state_d;
    logic [9:0]    idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    digit_q, digit_d;
    logic          err_q, err_d;

    logic       pix_acc;
    logic [9:0] wr_idx;

    // A start-of-frame pixel always lands at index 0, resyncing the counter.
    assign wr_idx  = pix_sof ? 10'd0 : idx_q;
    assign pix_acc = pix_valid && pix_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= nn_pkg::StLoad;
            idx_q   <= '0;
            tcnt_q  <= '0;
            digit_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            digit_q <= digit_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            nn_pkg::StLoad:   if (pix_acc && wr_idx == LAST_IDX) state_d = nn_pkg::StStart;
            nn_pkg::StStart:  state_d = nn_pkg::StRun;
            nn_pkg::StRun:    if (nn_done || tcnt_q == TO_LAST) state_d = nn_pkg::StResult;
            nn_pkg::StResult: if (digit_ready) state_d = nn_pkg::StLoad;
            default:          state_d = nn_pkg::StLoad;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        tcnt_d  = '0;
        digit_d = digit_q;
        err_d   = err_q;
        if (pix_acc) begin
            idx_d = (wr_idx == LAST_IDX) ? 10'd0 : wr_idx + 10'd1;
        end
        if (state_q == nn_pkg::StRun) begin
            tcnt_d = tcnt_q + 1'b1;
            // A done arriving on the timeout cycle still reports the real digit.
            if (nn_done) begin
                digit_d = nn_digit;
                err_d   = 1'b0;
            end else if (tcnt_q == TO_LAST) begin
                digit_d = 8'hFF;
                err_d   = 1'b1;
            end
        end
    end

    always_comb begin
        pix_ready   = 1'b0;
        nn_reset    = 1'b0;
        nn_enable   = 1'b0;
        digit_valid = 1'b0;
        unique case (state_q)
            nn_pkg::StLoad:   pix_ready   = 1'b1;
            nn_pkg::StStart:  nn_reset    = 1'b1;
            nn_pkg::StRun:    nn_enable   = 1'b1;
            nn_pkg::StResult: digit_valid = 1'b1;
            default:          pix_ready   = 1'b0;
        endcase
    end

    assign digit_out = digit_q;
    assign digit_err = err_q;

    nn_img_buf #(
        .N_PIX (N_PIX)
    ) u_img_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (pix_acc),
        .wr_idx_i  (wr_idx),
        .wr_data_i (pix_data),
        .img_o     (img)
    );

endmodule

// File: tb/tb_nn_img_loader.sv
// Directed bench for nn_img_loader: frame load, result capture, resync,
// source gaps, timeout and reset abort.
module tb_nn_img_loader;

    localparam int unsigned NP = 784;
    localparam int unsigned TO = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [7:0]     pix_data;
    logic           pix_sof;
    logic           pix_valid;
    logic           pix_ready;
    nn_pkg::pixel_t img [0:NP-1];
    logic           nn_reset;
    logic           nn_enable;
    logic [7:0]     nn_digit;
    logic           nn_done;
    logic [7:0]     digit_out;
    logic           digit_err;
    logic           digit_valid;
    logic           digit_ready;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    logic [7:0] src [0:NP-1];

    nn_img_loader #(
        .N_PIX   (NP),
        .TIMEOUT (TO)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .img         (img),
        .nn_reset    (nn_reset),
        .nn_enable   (nn_enable),
        .nn_digit    (nn_digit),
        .nn_done     (nn_done),
        .digit_out   (digit_out),
        .digit_err   (digit_err),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one pixel until accepted (bounded); returns just after the accepting edge.
    task automatic push(input logic [7:0] d, input logic sof);
        int   n;
        logic acc;
        pix_data  = d;
        pix_sof   = sof;
        pix_valid = 1'b1;
        n = 0;
        do begin
            acc = pix_ready;
            step();
            n++;
        end while (!acc && n < 50);
        if (acc) n_acc++;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < int'(NP); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            push(src[i], 1'b0);
        end
    endtask

    task automatic check_img(input string tag);
        int bad = 0;
        for (int i = 0; i < int'(NP); i++) begin
            if (img[i] !== nn_pkg::pixel_t'({1'b0, src[i][7:1]})) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic check_zero_img(input string tag);
        int bad = 0;
        for (int i = 0; i < int'(NP); i++) begin
            if (img[i] !== 8'sd0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    // Called one cycle after the last accepted pixel (cycle t+1).
    task automatic check_start(input string tag);
        chk({tag, "_nn_reset_t1"}, nn_reset, 1);
        chk({tag, "_pix_ready_t1"}, pix_ready, 0);
        chk({tag, "_nn_enable_t1"}, nn_enable, 0);
        step();
        chk({tag, "_nn_enable_t2"}, nn_enable, 1);
        chk({tag, "_nn_reset_t2"}, nn_reset, 0);
    endtask

    function automatic logic [7:0] pat_three(input int i);
        int r = i / 28;
        int c = i % 28;
        if (r >= 6 && r <= 21 && c >= 8 && c <= 19 &&
            (r == 6 || r == 7 || r == 13 || r == 14 || r == 20 || r == 21 || c >= 18)) begin
            return 8'd254;
        end
        return 8'(((r * 3 + c) % 16) * 2);
    endfunction

    initial begin
        int ready_hi;
        int bad;
        int n;

        reset       = 1'b1;
        pix_data    = '0;
        pix_sof     = 1'b0;
        pix_valid   = 1'b0;
        nn_digit    = '0;
        nn_done     = 1'b0;
        digit_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_nn_reset", nn_reset, 0);
        chk("rst_nn_enable", nn_enable, 0);
        chk("rst_digit_valid", digit_valid, 0);
        chk("rst_digit_out", digit_out, 0);
        chk("rst_digit_err", digit_err, 0);
        check_zero_img("rst_img");

        // Frame A: "3" image, no sof, no gaps; NN answers 3 after 40 RUN cycles.
        for (int i = 0; i < int'(NP); i++) src[i] = pat_three(i);
        n_acc = 0;
        send_frame(1'b0);
        chk("a_accepted", n_acc, NP);
        check_start("a");
        check_img("a_img");
        pix_valid = 1'b1;
        pix_data  = 8'hAA;
        ready_hi  = 0;
        repeat (39) begin
            if (pix_ready) ready_hi++;
            step();
        end
        nn_done  = 1'b1;
        nn_digit = 8'd3;
        step();
        nn_done   = 1'b0;
        nn_digit  = 8'd0;
        pix_valid = 1'b0;
        chk("a_run_no_ready", ready_hi, 0);
        chk("a_digit_valid", digit_valid, 1);
        chk("a_digit_out", digit_out, 3);
        chk("a_digit_err", digit_err, 0);
        chk("a_enable_drop", nn_enable, 0);
        check_img("a_img_frozen");
        bad = 0;
        repeat (10) begin
            step();
            if (digit_out !== 8'd3 || digit_valid !== 1'b1 || pix_ready !== 1'b0) bad++;
        end
        chk("a_hold_stable", bad, 0);
        digit_ready = 1'b1;
        step();
        digit_ready = 1'b0;
        chk("a_hs_pix_ready", pix_ready, 1);
        chk("a_hs_valid_drop", digit_valid, 0);

        // Frame B: 300 stray pixels, then sof resync, with source gaps; NN times out.
        src[0] = 8'hC8;
        for (int k = 1; k < int'(NP); k++) src[k] = 8'(k * 37 + 11);
        n_acc = 0;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) step();
            push(8'h10, 1'b0);
        end
        push(src[0], 1'b1);
        for (int k = 1; k < int'(NP) - 1; k++) begin
            repeat ($urandom_range(0, 2)) step();
            push(src[k], 1'b0);
        end
        chk("b_no_early_start", pix_ready, 1);
        chk("b_no_early_reset", nn_reset, 0);
        push(src[NP-1], 1'b0);
        chk("b_accepted", n_acc, 300 + NP);
        check_start("b");
        check_img("b_img");
        chk("b_img0", {24'b0, img[0]}, 32'h64);
        n = 0;
        while (nn_enable && n < 200) begin
            n++;
            step();
        end
        chk("b_timeout_cycles", n, TO);
        chk("b_to_valid", digit_valid, 1);
        chk("b_to_digit", digit_out, 8'hFF);
        chk("b_to_err", digit_err, 1);
        digit_ready = 1'b1;
        step();
        digit_ready = 1'b0;

        // Frame C: stray done during START is ignored; real done clears the error.
        for (int i = 0; i < int'(NP); i++) src[i] = 8'(255 - i);
        send_frame(1'b0);
        nn_done  = 1'b1;
        nn_digit = 8'd5;
        check_start("c");
        nn_done  = 1'b0;
        nn_digit = 8'd0;
        chk("c_start_done_ignored", digit_valid, 0);
        check_img("c_img");
        repeat (9) step();
        nn_done  = 1'b1;
        nn_digit = 8'd7;
        step();
        nn_done  = 1'b0;
        chk("c_digit_out", digit_out, 7);
        chk("c_digit_err", digit_err, 0);
        chk("c_digit_valid", digit_valid, 1);
        digit_ready = 1'b1;
        step();
        digit_ready = 1'b0;

        // Frame D: reset 20 cycles into RUN aborts everything.
        for (int i = 0; i < int'(NP); i++) src[i] = pat_three(i);
        send_frame(1'b0);
        check_start("d");
        repeat (19) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("d_rst_enable", nn_enable, 0);
        chk("d_rst_valid", digit_valid, 0);
        chk("d_rst_pix_ready", pix_ready, 1);
        chk("d_rst_digit_out", digit_out, 0);
        chk("d_rst_digit_err", digit_err, 0);
        check_zero_img("d_rst_img");

        // A partial frame cut by reset is discarded: the next frame needs all 784.
        for (int i = 0; i < 100; i++) push(8'h40, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < int'(NP) - 1; i++) push(src[i], 1'b0);
        chk("e_no_early_start", pix_ready, 1);
        push(src[NP-1], 1'b0);
        chk("e_start", nn_reset, 1);
        step();
        check_img("e_img");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
